core_halt_ctrl: RTL and testbench
=================================

# core_halt_ctrl

Run/halt sequencer between the AXI debug slave, the rv32i core and the register file's extra port. It stalls the core, waits until the core reports an instruction boundary, then performs one register-file access for the debug requester, and finally resumes or stays halted. It also provides host halt, run and single-step control. `cpu_stop` is the only path by which debug traffic may stall the core.

## Interface
- `STALL_TIMEOUT`, 255: maximum cycles in DRAIN waiting for `cpu_idle` before aborting; range 1..65535.
- `CLK` in 1: core clock; all state updates on the rising edge.
- `RSTn` in 1: reset is asynchronous and active-low.
- `dbg_req` in 1: debug access request; level, held until `dbg_done`.
- `dbg_we` in 1: 1 = write, 0 = read; stable while `dbg_req`.
- `dbg_addr` in `REG_ADDR_WIDTH`: register index 0..31.
- `dbg_wdata` in `DATA_WIDTH`: write data.
- `dbg_done` out 1: one-cycle completion pulse.
- `dbg_err` out 1: valid with `dbg_done`; 1 = timeout abort.
- `dbg_rdata` out `DATA_WIDTH`: registered read data; held until the next access completes.
- `ctrl_halt_req` in 1: single-cycle pulse; halts the core.
- `ctrl_run_req` in 1: single-cycle pulse; resumes the core.
- `ctrl_step_req` in 1: single-cycle pulse; executes one cycle of core run.
- `halted` out 1: high in HALTED.
- `cpu_stop` out 1: core stall request.
- `cpu_idle` in 1: core is stopped at an instruction boundary.
- `extra_addr` out `REG_ADDR_WIDTH`: register-file extra-port address.
- `extra_write_enable` out 1: register-file extra-port write strobe.
- `extra_write_data` out `DATA_WIDTH`: register-file extra-port write data.
- `extra_read_data` in `DATA_WIDTH`: combinational read data from the register file.

## Operation
- States: RUN, DRAIN, HALTED, ACCESS, DONE, STEP. Outputs are Moore, decoded from the registered state.
- `cpu_stop` = 1 in DRAIN, HALTED, ACCESS and DONE; 0 in RUN and STEP.
- Sticky flag `hold`:
  - Set by `ctrl_halt_req` and by STEP.
  - Cleared by `ctrl_run_req` in HALTED.
  - Decides the exit from DONE (HALTED if set, RUN if clear).
- RUN:
  - `dbg_req` or `ctrl_halt_req` -> DRAIN.
  - If both arrive in the same cycle, both are honoured: the access is performed, then the FSM goes to HALTED.
- DRAIN:
  - Counter increments each cycle.
  - `cpu_idle` = 1 -> ACCESS if `dbg_req` is pending, else HALTED.
  - Counter reaches `STALL_TIMEOUT` without `cpu_idle` -> DONE with `dbg_err` = 1 and no register-file access.
  - On that timeout with no `dbg_req` pending, go to RUN and clear `hold`.
- HALTED, priority order:
  - `dbg_req` -> ACCESS.
  - else `ctrl_step_req` -> STEP.
  - else `ctrl_run_req` -> RUN.
  - `ctrl_halt_req` is ignored.
- ACCESS (one cycle):
  - `extra_addr` = `dbg_addr`.
  - `extra_write_enable` = `dbg_we` && (`dbg_addr` != 0); a write to x0 is silently dropped, with `dbg_err` = 0.
  - `extra_write_data` = `dbg_wdata`.
  - Reads capture `extra_read_data` into `dbg_rdata` at the end of the cycle.
  - Next state is DONE.
- DONE (one cycle): `dbg_done` = 1; next state is HALTED if `hold`, else RUN.
- STEP (one cycle): `cpu_stop` = 0; set `hold`; next state is DRAIN.
- Outside ACCESS: `extra_write_enable` = 0 and `extra_addr` = 0.
- Counter width is $clog2(`STALL_TIMEOUT`+1). The counter clears on every entry to DRAIN and saturates; it never wraps.

## Timing
- Reset values (asynchronous, immediate):
  - State RUN, `hold` = 0, counter = 0.
  - `cpu_stop`, `halted`, `dbg_done`, `dbg_err` and `extra_write_enable` all 0.
  - `dbg_rdata`, `extra_addr` and `extra_write_data` all 0.
- Reset during ACCESS suppresses the write in that same cycle.
- Access latency from RUN with `cpu_idle` already 1:
  - `dbg_req` sampled at edge 0.
  - DRAIN during cycle 1; `cpu_idle` is seen at edge 1.
  - ACCESS in cycle 2.
  - `dbg_done` high in cycle 3 (3 cycles after the sample).
- Access latency from HALTED: `dbg_done` 2 cycles after `dbg_req` is sampled.
- The requester deasserts `dbg_req` in the cycle after `dbg_done`. The FSM does not re-accept `dbg_req` in the DONE cycle.
- DRAIN lasts at least 1 cycle even when `cpu_idle` is already high.
- A timeout produces `dbg_done` exactly `STALL_TIMEOUT`+1 cycles after DRAIN entry.

## Configuration
- Macro `HALT_CTRL_STEP_EN`.
- Defined: STEP state and `ctrl_step_req` are present as described above.
- Undefined:
  - The STEP state is absent and `ctrl_step_req` is ignored.
  - HALTED responds only to `dbg_req` and `ctrl_run_req`.

## Test plan
- Debug write, core in RUN, `cpu_idle` = 1, addr 1, data 0xDEADBEEF:
  - `cpu_stop` rises 1 cycle after the request.
  - `dbg_done` arrives 3 cycles after the request, with `dbg_err` = 0.
  - Core returns to RUN; a read of x1 returns 0xDEADBEEF.
- Write 0x12345678 to addr 0:
  - No `extra_write_enable` pulse.
  - `dbg_err` = 0; a read of x0 returns 0.
- `ctrl_halt_req`:
  - `halted` = 1.
  - Reads of x2 (0xFFFFFFFF) return the value with `dbg_done` 2 cycles after the request.
  - After `ctrl_run_req`, `cpu_stop` = 0 on the next cycle.
- `cpu_idle` held at 0 with `STALL_TIMEOUT` = 8:
  - `dbg_done` with `dbg_err` = 1 arrives 9 cycles after DRAIN entry.
  - No register-file write occurs; state is RUN.
- With `HALT_CTRL_STEP_EN`, in HALTED, `ctrl_step_req`:
  - Exactly one cycle of `cpu_stop` = 0, then DRAIN, then HALTED once `cpu_idle` is seen.
  - Without the macro, `cpu_stop` stays 1.
- Assert `RSTn` = 0 during ACCESS of a write to x3 (prior value 0xAAAA0000):
  - All outputs are 0 immediately.
  - x3 still reads 0xAAAA0000 after reset.

Source files
------------

// File: rtl/core_halt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_halt_ctrl
// Brief    : Run/halt sequencer. Stalls the rv32i core, waits for an
//            instruction boundary, performs one debug register-file access,
//            then resumes or stays halted. Host halt/run/single-step control.
//            Optional single-step support under macro HALT_CTRL_STEP_EN.
// Revision : 1.0
// ============================================================================
module core_halt_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STALL_TIMEOUT  = 255
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    // debug requester
    input  logic                      dbg_req,
    input  logic                      dbg_we,
    input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0]     dbg_wdata,
    output logic                      dbg_done,
    output logic                      dbg_err,
    output logic [DATA_WIDTH-1:0]     dbg_rdata,
    // host control
    input  logic                      ctrl_halt_req,
    input  logic                      ctrl_run_req,
    input  logic                      ctrl_step_req,
    output logic                      halted,
    // core handshake
    output logic                      cpu_stop,
    input  logic                      cpu_idle,
    // register-file extra port
    output logic [REG_ADDR_WIDTH-1:0] extra_addr,
    output logic                      extra_write_enable,
    output logic [DATA_WIDTH-1:0]     extra_write_data,
    input  logic [DATA_WIDTH-1:0]     extra_read_data
);

    localparam int                 c_CNT_W   = $clog2(STALL_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(STALL_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_HALTED = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4
`ifdef HALT_CTRL_STEP_EN
        ,
        ST_STEP   = 3'd5
`endif
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_hold;
    logic                    w_hold_nxt;
    logic                    r_err;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    w_timeout;

`ifndef HALT_CTRL_STEP_EN
    logic w_unused_step;
    assign w_unused_step = ctrl_step_req;
`endif

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_RUN;
            r_hold  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;

            // Counter is zero outside DRAIN, so every DRAIN entry starts at 0
            if (r_state != ST_DRAIN) begin
                r_cnt <= '0;
            end else if (r_cnt != c_TIMEOUT) begin
                r_cnt <= r_cnt + c_ONE;
            end

            if (w_timeout && dbg_req) begin
                r_err <= 1'b1;
            end else if (r_state == ST_ACCESS) begin
                r_err <= 1'b0;
            end

            if (r_state == ST_ACCESS && !dbg_we) begin
                r_rdata <= extra_read_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and hold-flag logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (dbg_req || ctrl_halt_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cpu_idle) begin
                    w_state_nxt = dbg_req ? ST_ACCESS : ST_HALTED;
                end else if (r_cnt == c_TIMEOUT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = dbg_req ? ST_DONE : ST_RUN;
                end
            end
            ST_HALTED: begin
                if (dbg_req) begin
                    w_state_nxt = ST_ACCESS;
`ifdef HALT_CTRL_STEP_EN
                end else if (ctrl_step_req) begin
                    w_state_nxt = ST_STEP;
`endif
                end else if (ctrl_run_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = r_hold ? ST_HALTED : ST_RUN;
            end
`ifdef HALT_CTRL_STEP_EN
            ST_STEP: begin
                w_state_nxt = ST_DRAIN;
            end
`endif
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        // Clears are applied last so they win over a coincident halt request
        w_hold_nxt = r_hold;
        if (ctrl_halt_req) begin
            w_hold_nxt = 1'b1;
        end
`ifdef HALT_CTRL_STEP_EN
        if (r_state == ST_STEP) begin
            w_hold_nxt = 1'b1;
        end
`endif
        if (r_state == ST_HALTED && w_state_nxt == ST_RUN) begin
            w_hold_nxt = 1'b0;
        end
        if (w_timeout && !dbg_req) begin
            w_hold_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs decoded from the registered state
    // ------------------------------------------------------------------
    always_comb begin
        cpu_stop           = 1'b0;
        halted             = 1'b0;
        dbg_done           = 1'b0;
        dbg_err            = 1'b0;
        extra_addr         = '0;
        extra_write_enable = 1'b0;
        extra_write_data   = '0;

        case (r_state)
            ST_DRAIN: begin
                cpu_stop = 1'b1;
            end
            ST_HALTED: begin
                cpu_stop = 1'b1;
                halted   = 1'b1;
            end
            ST_ACCESS: begin
                cpu_stop           = 1'b1;
                extra_addr         = dbg_addr;
                // x0 is hard-wired zero; writes to it are dropped without error
                extra_write_enable = dbg_we && (dbg_addr != '0);
                extra_write_data   = dbg_wdata;
            end
            ST_DONE: begin
                cpu_stop = 1'b1;
                dbg_done = 1'b1;
                dbg_err  = r_err;
            end
            default: begin
                cpu_stop = 1'b0;
            end
        endcase
    end

    assign dbg_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_core_halt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_halt_ctrl
// Brief    : Directed self-checking bench for core_halt_ctrl with a small
//            register-file model on the extra port.
// Revision : 1.0
// ============================================================================
module tb_core_halt_ctrl;

    localparam int c_TO = 8;
`ifdef HALT_CTRL_STEP_EN
    localparam bit c_STEP = 1'b1;
`else
    localparam bit c_STEP = 1'b0;
`endif

    logic        CLK;
    logic        RSTn;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_done;
    logic        dbg_err;
    logic [31:0] dbg_rdata;
    logic        ctrl_halt_req;
    logic        ctrl_run_req;
    logic        ctrl_step_req;
    logic        halted;
    logic        cpu_stop;
    logic        cpu_idle;
    logic [4:0]  extra_addr;
    logic        extra_write_enable;
    logic [31:0] extra_write_data;
    logic [31:0] extra_read_data;

    core_halt_ctrl #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .STALL_TIMEOUT  (c_TO)
    ) u_dut (
        .CLK                (CLK),
        .RSTn               (RSTn),
        .dbg_req            (dbg_req),
        .dbg_we             (dbg_we),
        .dbg_addr           (dbg_addr),
        .dbg_wdata          (dbg_wdata),
        .dbg_done           (dbg_done),
        .dbg_err            (dbg_err),
        .dbg_rdata          (dbg_rdata),
        .ctrl_halt_req      (ctrl_halt_req),
        .ctrl_run_req       (ctrl_run_req),
        .ctrl_step_req      (ctrl_step_req),
        .halted             (halted),
        .cpu_stop           (cpu_stop),
        .cpu_idle           (cpu_idle),
        .extra_addr         (extra_addr),
        .extra_write_enable (extra_write_enable),
        .extra_write_data   (extra_write_data),
        .extra_read_data    (extra_read_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register-file model: x0 reads zero, writes on the rising edge
    logic [31:0] rf [32] = '{default: 32'h0};
    int          wr_pulses = 0;
    assign extra_read_data = (extra_addr == 5'd0) ? 32'h0 : rf[extra_addr];
    always @(posedge CLK) begin
        if (extra_write_enable) begin
            wr_pulses <= wr_pulses + 1;
            if (extra_addr != 5'd0) rf[extra_addr] <= extra_write_data;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Issues one debug access at a negedge; returns cycles to dbg_done (-1 on expiry)
    task automatic dbg_access(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                              input logic with_halt, output int lat, output logic err,
                              output logic stop1);
        dbg_req       = 1'b1;
        dbg_we        = we;
        dbg_addr      = addr;
        dbg_wdata     = wd;
        ctrl_halt_req = with_halt;
        lat   = -1;
        err   = 1'b0;
        stop1 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            ctrl_halt_req = 1'b0;
            if (i == 1) stop1 = cpu_stop;
            if (dbg_done) begin
                lat = i;
                err = dbg_err;
                break;
            end
        end
        @(negedge CLK);
        dbg_req = 1'b0;
        dbg_we  = 1'b0;
    endtask

    task automatic pulse_halt();
        ctrl_halt_req = 1'b1;
        @(negedge CLK);
        ctrl_halt_req = 1'b0;
        @(negedge CLK);
    endtask

    task automatic pulse_run();
        ctrl_run_req = 1'b1;
        @(negedge CLK);
        ctrl_run_req = 1'b0;
    endtask

    int   lat;
    int   wp;
    int   dcnt;
    logic err;
    logic stop1;
    logic s1, s2, h2, h3;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RSTn = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        ctrl_halt_req = 1'b0; ctrl_run_req = 1'b0; ctrl_step_req = 1'b0; cpu_idle = 1'b1;
        repeat (2) @(negedge CLK);

        // Reset state
        check_val("rst_cpu_stop", 32'(cpu_stop), 32'd0);
        check_val("rst_halted", 32'(halted), 32'd0);
        check_val("rst_done", 32'(dbg_done), 32'd0);
        check_val("rst_err", 32'(dbg_err), 32'd0);
        check_val("rst_we", 32'(extra_write_enable), 32'd0);
        check_val("rst_rdata", dbg_rdata, 32'd0);
        RSTn = 1'b1;
        @(negedge CLK);

        // Write x1 from RUN
        dbg_access(1'b1, 5'd1, 32'hDEADBEEF, 1'b0, lat, err, stop1);
        check_val("wr1_lat", 32'(lat), 32'd3);
        check_val("wr1_stop_first", 32'(stop1), 32'd1);
        check_val("wr1_err", 32'(err), 32'd0);
        check_val("wr1_run_stop", 32'(cpu_stop), 32'd0);
        check_val("wr1_run_halted", 32'(halted), 32'd0);
        dbg_access(1'b0, 5'd1, 32'h0, 1'b0, lat, err, stop1);
        check_val("rd1_lat", 32'(lat), 32'd3);
        check_val("rd1_data", dbg_rdata, 32'hDEADBEEF);

        // Write to x0 is dropped
        wp = wr_pulses;
        dbg_access(1'b1, 5'd0, 32'h12345678, 1'b0, lat, err, stop1);
        check_val("wr0_no_pulse", 32'(wr_pulses), 32'(wp));
        check_val("wr0_err", 32'(err), 32'd0);
        dbg_access(1'b0, 5'd0, 32'h0, 1'b0, lat, err, stop1);
        check_val("rd0_data", dbg_rdata, 32'h0);

        // Host halt, read from HALTED, run
        dbg_access(1'b1, 5'd2, 32'hFFFFFFFF, 1'b0, lat, err, stop1);
        pulse_halt();
        check_val("halt_halted", 32'(halted), 32'd1);
        dbg_access(1'b0, 5'd2, 32'h0, 1'b0, lat, err, stop1);
        check_val("rd2_lat_halted", 32'(lat), 32'd2);
        check_val("rd2_data", dbg_rdata, 32'hFFFFFFFF);
        check_val("rd2_still_halted", 32'(halted), 32'd1);
        pulse_halt();
        check_val("halt_ignored", 32'(halted), 32'd1);
        pulse_run();
        check_val("run_stop", 32'(cpu_stop), 32'd0);
        check_val("run_halted", 32'(halted), 32'd0);

        // Single step from HALTED
        pulse_halt();
        ctrl_step_req = 1'b1;
        @(negedge CLK);
        ctrl_step_req = 1'b0;
        s1 = cpu_stop;
        @(negedge CLK);
        s2 = cpu_stop; h2 = halted;
        @(negedge CLK);
        h3 = halted;
        check_val("step_stop_c1", 32'(s1), c_STEP ? 32'd0 : 32'd1);
        check_val("step_stop_c2", 32'(s2), 32'd1);
        check_val("step_halted_c2", 32'(h2), c_STEP ? 32'd0 : 32'd1);
        check_val("step_halted_c3", 32'(h3), 32'd1);
        pulse_run();

        // Debug timeout: no write, DONE with err, back to RUN
        cpu_idle = 1'b0;
        wp = wr_pulses;
        dbg_access(1'b1, 5'd5, 32'h55, 1'b0, lat, err, stop1);
        check_val("to_lat", 32'(lat), 32'(c_TO + 2));
        check_val("to_err", 32'(err), 32'd1);
        check_val("to_no_write", 32'(wr_pulses), 32'(wp));
        check_val("to_run_stop", 32'(cpu_stop), 32'd0);
        check_val("to_run_halted", 32'(halted), 32'd0);
        cpu_idle = 1'b1;
        dbg_access(1'b0, 5'd5, 32'h0, 1'b0, lat, err, stop1);
        check_val("to_x5_unchanged", dbg_rdata, 32'h0);

        // Halt timeout: returns to RUN silently with hold cleared
        cpu_idle = 1'b0;
        ctrl_halt_req = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            ctrl_halt_req = 1'b0;
            if (dbg_done) dcnt++;
        end
        check_val("hto_no_done", 32'(dcnt), 32'd0);
        check_val("hto_stop", 32'(cpu_stop), 32'd0);
        check_val("hto_halted", 32'(halted), 32'd0);
        cpu_idle = 1'b1;
        dbg_access(1'b1, 5'd6, 32'h66, 1'b0, lat, err, stop1);
        check_val("hto_hold_clear", 32'(halted), 32'd0);

        // Access and halt in the same cycle: access done, then HALTED
        dbg_access(1'b0, 5'd6, 32'h0, 1'b1, lat, err, stop1);
        check_val("both_lat", 32'(lat), 32'd3);
        check_val("both_data", dbg_rdata, 32'h66);
        check_val("both_halted", 32'(halted), 32'd1);
        pulse_run();

        // Reset during ACCESS suppresses the write
        dbg_access(1'b1, 5'd3, 32'hAAAA0000, 1'b0, lat, err, stop1);
        pulse_halt();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'h00001234;
        @(negedge CLK);
        check_val("acc_we", 32'(extra_write_enable), 32'd1);
        RSTn = 1'b0;
        #1;
        check_val("arst_we", 32'(extra_write_enable), 32'd0);
        check_val("arst_addr", 32'(extra_addr), 32'd0);
        check_val("arst_wdata", extra_write_data, 32'd0);
        check_val("arst_stop", 32'(cpu_stop), 32'd0);
        check_val("arst_halted", 32'(halted), 32'd0);
        check_val("arst_rdata", dbg_rdata, 32'd0);
        dbg_req = 1'b0; dbg_we = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        dbg_access(1'b0, 5'd3, 32'h0, 1'b0, lat, err, stop1);
        check_val("arst_x3_kept", dbg_rdata, 32'hAAAA0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
